hs32_mem_arbiter: RTL and testbench

Memory-side responder for the HS32 core bus, the other end of the fetch unit's stb/ack/stl handshake. It accepts single-word requests from two initiators: the fetch port (read-only) and the execute port (read/write). It grants one at a time with execute priority, drives a fixed-latency synchronous SRAM, and returns data with a one-cycle ack. Requests it cannot serve get a one-cycle stall, which the initiator treats as abort-and-retry.

---
 rtl/hs32_mem_arbiter_pkg.sv | 25 ++
 rtl/hs32_mem_port.sv | 33 +++
 rtl/hs32_mem_arbiter.sv | 150 +++++++++++++++
 tb/tb_hs32_mem_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hs32_mem_arbiter_pkg.sv
// Shared definitions for the HS32 memory arbiter: FSM states, port ids and
// the request address check used at acceptance time.
package hs32_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_id_t;

    // Wide enough to hold LATENCY-1 for the full legal range 1..7.
    localparam int CNT_W = 3;

    // A request is servable only if word aligned and inside the SRAM window.
    function automatic logic addr_ok(input logic [31:0] addr, input int unsigned addr_w);
        return (addr[1:0] == 2'b00) && ((addr >> (addr_w + 2)) == 32'd0);
    endfunction

endpackage

// File: rtl/hs32_mem_port.sv
// One initiator's response side: read-data register plus registered ack and
// stall pulses, all driven by single-cycle strobes from the arbiter FSM.
module hs32_mem_port (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        done,
    input  logic        reject,
    input  logic [31:0] rdata,
    output logic [31:0] dtr,
    output logic        ack,
    output logic        stl
);

    // NOTE: synchronous active-low reset, and every flop is updated with <= so
    // all registers sample the same pre-edge values regardless of block order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            dtr <= '0;
            ack <= 1'b0;
            stl <= 1'b0;
        end else begin
            ack <= done;
            // A strobe colliding with this port's own completion is answered
            // by the ack alone, so ack and stall never overlap on one port.
            stl <= reject && !done;
            if (load) begin
                dtr <= rdata;
            end
        end
    end

endmodule

// File: rtl/hs32_mem_arbiter.sv
// Two-initiator SRAM responder: execute-priority grant, fixed-latency read
// capture, single-cycle ack, and single-cycle stall for unservable strobes.
module hs32_mem_arbiter
    import hs32_mem_arbiter_pkg::*;
#(
    parameter int LATENCY = 1,
    parameter int ADDR_W  = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       addri,
    input  logic              stbi,
    output logic [31:0]       dtri,
    output logic              acki,
    output logic              stli,
    input  logic [31:0]       addrd,
    input  logic [31:0]       dtwd,
    input  logic              rwd,
    input  logic              stbd,
    output logic [31:0]       dtrd,
    output logic              ackd,
    output logic              stld,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_din,
    output logic              sram_en,
    output logic              sram_we,
    input  logic [31:0]       sram_dout
);

    arb_state_t       state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    port_id_t         req_port, req_port_nx;
    logic             req_we, req_we_nx;
    logic [ADDR_W-1:0] addr_nx;
    logic [31:0]      din_nx;
    logic             en_nx, we_nx;

    logic free, acc_i, acc_d, rej_i, rej_d;
    logic capture, done_any;
    logic load_i, load_d, done_i, done_d;

    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        req_port_nx = req_port;
        req_we_nx   = req_we;
        addr_nx     = sram_addr;
        din_nx      = sram_din;
        en_nx       = 1'b0;
        we_nx       = 1'b0;
        capture     = 1'b0;
        done_any    = 1'b0;

        // DONE is the ack cycle; the SRAM is already free, so it accepts too.
        free  = (state == IDLE) || (state == DONE);
        acc_d = free && stbd && addr_ok(addrd, ADDR_W);
        acc_i = free && stbi && !acc_d && addr_ok(addri, ADDR_W);
        rej_d = stbd && !acc_d;
        rej_i = stbi && !acc_i;

        case (state)
            IDLE, DONE: begin
                if (acc_d || acc_i) begin
                    state_nx    = ISSUE;
                    en_nx       = 1'b1;
                    req_port_nx = acc_d ? PORT_D : PORT_I;
                    req_we_nx   = acc_d && rwd;
                    we_nx       = acc_d && rwd;
                    addr_nx     = acc_d ? addrd[ADDR_W+1:2] : addri[ADDR_W+1:2];
                    din_nx      = acc_d ? dtwd : 32'd0;
                end else begin
                    state_nx = IDLE;
                end
            end
            ISSUE: begin
                if (req_we) begin
                    state_nx = DONE;
                    done_any = 1'b1;
                end else begin
                    state_nx = WAIT;
                    cnt_nx   = CNT_W'(LATENCY - 1);
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_nx = DONE;
                    capture  = 1'b1;
                    done_any = 1'b1;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase

        load_i = capture && (req_port == PORT_I);
        load_d = capture && (req_port == PORT_D);
        done_i = done_any && (req_port == PORT_I);
        done_d = done_any && (req_port == PORT_D);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            req_port  <= PORT_I;
            req_we    <= 1'b0;
            sram_addr <= '0;
            sram_din  <= '0;
            sram_en   <= 1'b0;
            sram_we   <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            req_port  <= req_port_nx;
            req_we    <= req_we_nx;
            sram_addr <= addr_nx;
            sram_din  <= din_nx;
            sram_en   <= en_nx;
            sram_we   <= we_nx;
        end
    end

    hs32_mem_port u_port_i (
        .clk    (clk),
        .reset  (reset),
        .load   (load_i),
        .done   (done_i),
        .reject (rej_i),
        .rdata  (sram_dout),
        .dtr    (dtri),
        .ack    (acki),
        .stl    (stli)
    );

    hs32_mem_port u_port_d (
        .clk    (clk),
        .reset  (reset),
        .load   (load_d),
        .done   (done_d),
        .reject (rej_d),
        .rdata  (sram_dout),
        .dtr    (dtrd),
        .ack    (ackd),
        .stl    (stld)
    );

endmodule

// File: tb/tb_hs32_mem_arbiter.sv
// Bench for hs32_mem_arbiter: one instance per LATENCY 1..7, each with its own
// SRAM model; a scoreboard of expected ack/stall pulses checked every cycle.
module tb_hs32_mem_arbiter;

    localparam int N  = 7;
    localparam int AW = 12;

    typedef struct {
        int          inst;
        bit          port_d;
        bit          is_ack;
        int          due;
        logic [31:0] data;
    } sb_t;

    typedef struct {
        bit          port_d;
        bit          rw;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          accept;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst   [1:N];
    logic [31:0] addri [1:N];
    logic        stbi  [1:N];
    logic [31:0] dtri  [1:N];
    logic        acki  [1:N];
    logic        stli  [1:N];
    logic [31:0] addrd [1:N];
    logic [31:0] dtwd  [1:N];
    logic        rwd   [1:N];
    logic        stbd  [1:N];
    logic [31:0] dtrd  [1:N];
    logic        ackd  [1:N];
    logic        stld  [1:N];

    int n_cmp = 0;
    int n_bad = 0;
    sb_t sb_q[$];
    logic [31:0] last_rd [1:N][0:1];
    logic [31:0] wr_over [int];

    function automatic logic [31:0] init_word(input int k);
        return 32'hC0DE_0000 + 32'(k);
    endfunction

    function automatic logic [31:0] model_rd(input int g, input int w);
        if (wr_over.exists(g * 4096 + w)) return wr_over[g * 4096 + w];
        return init_word(w);
    endfunction

    for (genvar g = 1; g <= N; g++) begin : gen_dut
        logic [AW-1:0] sram_addr;
        logic [31:0]   sram_din;
        logic [31:0]   sram_dout;
        logic          sram_en;
        logic          sram_we;
        logic [31:0]   mem  [0:(1<<AW)-1];
        logic [31:0]   pipe [0:N-1];

        hs32_mem_arbiter #(.LATENCY(g), .ADDR_W(AW)) u_dut (
            .clk       (clk),
            .reset     (rst[g]),
            .addri     (addri[g]),
            .stbi      (stbi[g]),
            .dtri      (dtri[g]),
            .acki      (acki[g]),
            .stli      (stli[g]),
            .addrd     (addrd[g]),
            .dtwd      (dtwd[g]),
            .rwd       (rwd[g]),
            .stbd      (stbd[g]),
            .dtrd      (dtrd[g]),
            .ackd      (ackd[g]),
            .stld      (stld[g]),
            .sram_addr (sram_addr),
            .sram_din  (sram_din),
            .sram_en   (sram_en),
            .sram_we   (sram_we),
            .sram_dout (sram_dout)
        );

        // Read data is valid only in the cycle exactly g cycles after sram_en.
        always @(posedge clk) begin
            if (sram_en && sram_we) mem[sram_addr] <= sram_din;
            pipe[0] <= (sram_en && !sram_we) ? mem[sram_addr] : 32'hBAD0_BAD0;
            for (int s = 1; s < N; s++) pipe[s] <= pipe[s-1];
        end
        assign sram_dout = pipe[g-1];

        initial begin
            for (int k = 0; k < (1 << AW); k++) mem[k] = init_word(k);
            if (g == 1) mem[16] = 32'hDEADBEEF;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic match_pulse(input int g, input bit pd, input logic ack, input logic stl,
                               input logic [31:0] dat);
        int idx;
        idx = -1;
        if (ack !== 1'b1 && stl !== 1'b1) return;
        if (ack === 1'b1) check($sformatf("ack_stall_excl_i%0d_p%0d", g, pd), 32'(stl), 32'd0);
        for (int i = 0; i < sb_q.size(); i++)
            if (idx < 0 && sb_q[i].inst == g && sb_q[i].port_d == pd) idx = i;
        if (idx < 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_pulse: inst %0d port_d %0d ack %b stall %b (cycle %0d)",
                     g, pd, ack, stl, cyc);
            return;
        end
        check($sformatf("pulse_kind_i%0d_p%0d", g, pd), 32'(ack === 1'b1), 32'(sb_q[idx].is_ack));
        check($sformatf("pulse_cycle_i%0d_p%0d", g, pd), 32'(cyc), 32'(sb_q[idx].due));
        if (sb_q[idx].is_ack) check($sformatf("ack_data_i%0d_p%0d", g, pd), dat, sb_q[idx].data);
        sb_q.delete(idx);
    endtask

    always @(negedge clk) begin
        for (int g = 1; g <= N; g++) begin
            match_pulse(g, 1'b0, acki[g], stli[g], dtri[g]);
            match_pulse(g, 1'b1, ackd[g], stld[g], dtrd[g]);
        end
        for (int i = sb_q.size() - 1; i >= 0; i--) begin
            if (sb_q[i].due < cyc) begin
                n_cmp++;
                n_bad++;
                $display("FAIL missing_pulse: inst %0d port_d %0d ack %0d due %0d, now cycle %0d",
                         sb_q[i].inst, sb_q[i].port_d, sb_q[i].is_ack, sb_q[i].due, cyc);
                sb_q.delete(i);
            end
        end
    end

    // Inputs are scrambled after each strobe cycle so latching is exercised.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            for (int g = 1; g <= N; g++) begin
                stbi[g]  = 1'b0;
                stbd[g]  = 1'b0;
                addri[g] = 32'hFFFF_FFFF;
                addrd[g] = 32'hFFFF_FFFF;
                dtwd[g]  = 32'hFFFF_FFFF;
                rwd[g]   = 1'b1;
            end
        end
    endtask

    task automatic req(input int g, input bit pd, input bit rw, input logic [31:0] addr,
                       input logic [31:0] wdata, input bit accept);
        sb_t e;
        if (pd) begin
            stbd[g]  = 1'b1;
            addrd[g] = addr;
            dtwd[g]  = wdata;
            rwd[g]   = rw;
        end else begin
            stbi[g]  = 1'b1;
            addri[g] = addr;
        end
        e.inst   = g;
        e.port_d = pd;
        e.data   = 32'd0;
        if (!accept) begin
            e.is_ack = 1'b0;
            e.due    = cyc + 1;
        end else begin
            e.is_ack = 1'b1;
            if (pd && rw) begin
                e.due = cyc + 2;
                e.data = last_rd[g][1];
                wr_over[g * 4096 + int'(addr[13:2])] = wdata;
            end else begin
                e.due = cyc + 2 + g;
                e.data = model_rd(g, int'(addr[13:2]));
                last_rd[g][int'(pd)] = e.data;
            end
        end
        sb_q.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt [0:10];

        for (int g = 1; g <= N; g++) begin
            rst[g]   = 1'b0;
            stbi[g]  = 1'b0;
            stbd[g]  = 1'b0;
            addri[g] = 32'd0;
            addrd[g] = 32'd0;
            dtwd[g]  = 32'd0;
            rwd[g]   = 1'b0;
            last_rd[g][0] = 32'd0;
            last_rd[g][1] = 32'd0;
        end
        wr_over[4096 + 16] = 32'hDEADBEEF;

        step(3);
        @(negedge clk);
        check("rst_acki", 32'(acki[1]), 32'd0);
        check("rst_ackd", 32'(ackd[1]), 32'd0);
        check("rst_stli", 32'(stli[1]), 32'd0);
        check("rst_stld", 32'(stld[1]), 32'd0);
        check("rst_dtri", dtri[1], 32'd0);
        check("rst_dtrd", dtrd[1], 32'd0);
        check("rst_sram_en", 32'(gen_dut[1].sram_en), 32'd0);
        check("rst_sram_we", 32'(gen_dut[1].sram_we), 32'd0);
        check("rst_sram_addr", 32'(gen_dut[1].sram_addr), 32'd0);
        check("rst_sram_din", gen_dut[1].sram_din, 32'd0);
        for (int g = 1; g <= N; g++) rst[g] = 1'b1;
        step(2);

        // {port_d, rw, addr, wdata, accept}
        vt[0]  = '{1'b0, 1'b0, 32'h0000_0040, 32'h0,          1'b1};
        vt[1]  = '{1'b1, 1'b1, 32'h0000_0008, 32'h1234_5678,  1'b1};
        vt[2]  = '{1'b0, 1'b0, 32'h0000_0008, 32'h0,          1'b1};
        vt[3]  = '{1'b0, 1'b0, 32'h0000_0002, 32'h0,          1'b0};
        vt[4]  = '{1'b1, 1'b0, 32'h0000_4000, 32'h0,          1'b0};
        vt[5]  = '{1'b1, 1'b0, 32'h0000_0008, 32'h0,          1'b1};
        vt[6]  = '{1'b1, 1'b1, 32'h0000_3FFC, 32'hA5A5_5A5A,  1'b1};
        vt[7]  = '{1'b0, 1'b0, 32'h0000_3FFC, 32'h0,          1'b1};
        vt[8]  = '{1'b1, 1'b1, 32'h0000_0001, 32'h0BAD_0001,  1'b0};
        vt[9]  = '{1'b0, 1'b0, 32'h8000_0040, 32'h0,          1'b0};
        vt[10] = '{1'b1, 1'b0, 32'h0000_0040, 32'h0,          1'b1};

        for (int i = 0; i <= 10; i++) begin
            req(1, vt[i].port_d, vt[i].rw, vt[i].addr, vt[i].wdata, vt[i].accept);
            step(1);
            @(negedge clk);
            check($sformatf("vec%0d_sram_en", i), 32'(gen_dut[1].sram_en), 32'(vt[i].accept));
            if (vt[i].accept) begin
                check($sformatf("vec%0d_sram_addr", i), 32'(gen_dut[1].sram_addr),
                      32'(vt[i].addr[13:2]));
                check($sformatf("vec%0d_sram_we", i), 32'(gen_dut[1].sram_we),
                      32'(vt[i].port_d && vt[i].rw));
                if (vt[i].port_d && vt[i].rw)
                    check($sformatf("vec%0d_sram_din", i), gen_dut[1].sram_din, vt[i].wdata);
            end
            step(6);
        end

        // Collision: execute wins, fetch stalls, retries while busy, then in the ack cycle.
        req(1, 1'b0, 1'b0, 32'h0000_0040, 32'h0, 1'b0);
        req(1, 1'b1, 1'b0, 32'h0000_0008, 32'h0, 1'b1);
        step(2);
        req(1, 1'b0, 1'b0, 32'h0000_0040, 32'h0, 1'b0);
        step(1);
        req(1, 1'b0, 1'b0, 32'h0000_0040, 32'h0, 1'b1);
        step(8);

        // Reset mid-read on LATENCY=4: the in-flight read is dropped without an ack.
        req(4, 1'b0, 1'b0, 32'h0000_0020, 32'h0, 1'b1);
        step(10);
        stbi[4]  = 1'b1;
        addri[4] = 32'h0000_0024;
        step(2);
        rst[4] = 1'b0;
        step(1);
        @(negedge clk);
        check("mid_rst_acki", 32'(acki[4]), 32'd0);
        check("mid_rst_stli", 32'(stli[4]), 32'd0);
        check("mid_rst_dtri", dtri[4], 32'd0);
        check("mid_rst_ackd", 32'(ackd[4]), 32'd0);
        check("mid_rst_stld", 32'(stld[4]), 32'd0);
        check("mid_rst_dtrd", dtrd[4], 32'd0);
        check("mid_rst_sram_en", 32'(gen_dut[4].sram_en), 32'd0);
        check("mid_rst_sram_we", 32'(gen_dut[4].sram_we), 32'd0);
        check("mid_rst_sram_addr", 32'(gen_dut[4].sram_addr), 32'd0);
        check("mid_rst_sram_din", gen_dut[4].sram_din, 32'd0);
        rst[4] = 1'b1;
        last_rd[4][0] = 32'd0;
        last_rd[4][1] = 32'd0;
        step(10);
        req(4, 1'b0, 1'b0, 32'h0000_0028, 32'h0, 1'b1);
        step(10);

        // Latency sweep: 8 fetch reads per instance, each strobe in the previous ack cycle.
        for (int g = 1; g <= N; g++) begin
            for (int k = 0; k < 8; k++) begin
                req(g, 1'b0, 1'b0, 32'h0000_0100 + 32'(k * 4), 32'h0, 1'b1);
                step(g + 2);
            end
            step(g + 4);
        end

        step(12);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
